// File: rtl/automorph_if.sv
// FIFO-side bus of automorph_unit: input line read port and lane-banked output write port.
interface automorph_if #(
  parameter int unsigned BIT_WIDTH  = 54,
  parameter int unsigned LINE_SIZE  = 4,
  parameter int unsigned ADDR_WIDTH = 9
);
  logic                            in_empty;
  logic [ADDR_WIDTH-1:0]           in_addr;
  logic [BIT_WIDTH*LINE_SIZE-1:0]  in_data;
  logic                            in_rd_finish;
  logic                            out_full;
  logic [LINE_SIZE-1:0]            out_wen;
  logic [ADDR_WIDTH*LINE_SIZE-1:0] out_addr;
  logic [BIT_WIDTH*LINE_SIZE-1:0]  out_data;
  logic                            out_wr_finish;

  modport master (
    input  in_empty, in_data, out_full,
    output in_addr, in_rd_finish, out_wen, out_addr, out_data, out_wr_finish
  );

  modport slave (
    output in_empty, in_data, out_full,
    input  in_addr, in_rd_finish, out_wen, out_addr, out_data, out_wr_finish
  );
endinterface

// File: rtl/automorph_unit.sv
// automorph_unit: applies X -> X^k (k odd, runtime) to NUM_POLY RLWE polynomials per start.
// Optional macro AUTOMORPH_IDX_CHECK_EN: reject even k with an err pulse instead of processing it.
module automorph_unit #(
  parameter int unsigned BIT_WIDTH  = 54,
  parameter int unsigned LINE_SIZE  = 4,
  parameter int unsigned LOG2_N_MAX = 11,
  parameter int unsigned NUM_POLY   = 2,
  parameter int unsigned ADDR_WIDTH = LOG2_N_MAX - $clog2(LINE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [BIT_WIDTH-1:0]  q,
  input  logic [4:0]            log2_len,
  input  logic [LOG2_N_MAX:0]   auto_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  automorph_if.master           fifo
);
  localparam int unsigned LL  = $clog2(LINE_SIZE);
  localparam int unsigned IW  = LOG2_N_MAX + 1;
  localparam int unsigned PCW = $clog2(NUM_POLY + 1);

  typedef enum logic [2:0] {IDLE, WAIT, READ, DRAIN, FIN} state_t;

  state_t          state;
  logic [IW-1:0]   k_r;
  logic [4:0]      len_r;
  logic [PCW-1:0]  poly_cnt;
  logic            drain_cnt;
  logic [IW-1:0]   acc;
  logic            s1_vld;
  logic            s1_last;
  logic [IW-1:0]   s1_acc;
  logic            idx_ok;

  logic [IW-1:0]         n_bit;
  logic [IW-1:0]         n_m1;
  logic [IW-1:0]         mask2n;
  logic [IW-1:0]         step;
  logic [ADDR_WIDTH-1:0] last_line;

  logic [IW-1:0]         lane_off  [LINE_SIZE];
  logic [BIT_WIDTH-1:0]  src_val   [LINE_SIZE];
  logic [IW-1:0]         src_pos   [LINE_SIZE];
  logic [BIT_WIDTH-1:0]  lane_data [LINE_SIZE];
  logic [ADDR_WIDTH-1:0] lane_addr [LINE_SIZE];

`ifdef AUTOMORPH_IDX_CHECK_EN
  assign idx_ok = auto_idx[0];
`else
  assign idx_ok = 1'b1;
`endif

  // Length-derived constants; all index arithmetic is mod 2N via mask2n.
  always_comb begin
    n_bit     = IW'(1) << len_r;
    n_m1      = n_bit - IW'(1);
    mask2n    = {n_m1[IW-2:0], 1'b1};
    step      = (k_r << LL) & mask2n;
    last_line = ADDR_WIDTH'((n_bit >> LL) - IW'(1));
  end

  // Per-lane source exponent, negation and destination for the line in stage 1.
  always_comb begin
    for (int unsigned i = 0; i < LINE_SIZE; i++) begin
      logic [IW-1:0]        d;
      logic [BIT_WIDTH-1:0] c;
      lane_off[i] = IW'(IW'(i) * k_r);
      d           = (s1_acc + lane_off[i]) & mask2n;
      c           = fifo.in_data[i*BIT_WIDTH +: BIT_WIDTH];
      src_pos[i]  = d & n_m1;
      src_val[i]  = ((d & n_bit) != '0 && c != '0) ? q - c : c;
    end
  end

  // Route each source lane to its destination lane (distinct for odd k).
  always_comb begin
    for (int unsigned o = 0; o < LINE_SIZE; o++) begin
      lane_data[o] = '0;
      lane_addr[o] = '0;
      for (int unsigned i = 0; i < LINE_SIZE; i++) begin
        if (src_pos[i][LL-1:0] == LL'(o)) begin
          lane_data[o] = src_val[i];
          lane_addr[o] = ADDR_WIDTH'(src_pos[i] >> LL);
        end
      end
    end
  end

  // Control FSM: start acceptance, line address sequencing, per-polynomial bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      k_r                <= '0;
      len_r              <= '0;
      poly_cnt           <= '0;
      drain_cnt          <= 1'b0;
      acc                <= '0;
      fifo.in_addr       <= '0;
      fifo.out_wr_finish <= 1'b0;
    end else begin
      done               <= 1'b0;
      err                <= 1'b0;
      fifo.out_wr_finish <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && idx_ok) begin
            state    <= WAIT;
            busy     <= 1'b1;
            k_r      <= auto_idx;
            len_r    <= log2_len;
            poly_cnt <= '0;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        WAIT: begin
          if (!fifo.in_empty && !fifo.out_full) begin
            state        <= READ;
            fifo.in_addr <= '0;
            acc          <= '0;
          end
        end
        READ: begin
          acc <= (acc + step) & mask2n;
          if (fifo.in_addr == last_line) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            fifo.in_addr <= fifo.in_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state              <= FIN;
            fifo.out_wr_finish <= 1'b1;
          end
        end
        FIN: begin
          if (poly_cnt == PCW'(NUM_POLY - 1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            poly_cnt <= '0;
          end else begin
            state    <= WAIT;
            poly_cnt <= poly_cnt + PCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data pipeline: stage 1 tracks the line whose data returns now, stage 2 registers the writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld            <= 1'b0;
      s1_last           <= 1'b0;
      s1_acc            <= '0;
      fifo.out_wen      <= '0;
      fifo.out_addr     <= '0;
      fifo.out_data     <= '0;
      fifo.in_rd_finish <= 1'b0;
    end else begin
      s1_vld            <= (state == READ);
      s1_last           <= (state == READ) && (fifo.in_addr == last_line);
      s1_acc            <= acc;
      fifo.out_wen      <= {LINE_SIZE{s1_vld}};
      fifo.in_rd_finish <= s1_vld && s1_last;
      for (int unsigned o = 0; o < LINE_SIZE; o++) begin
        fifo.out_data[o*BIT_WIDTH +: BIT_WIDTH]   <= s1_vld ? lane_data[o] : '0;
        fifo.out_addr[o*ADDR_WIDTH +: ADDR_WIDTH] <= s1_vld ? lane_addr[o] : '0;
      end
    end
  end
endmodule

// File: tb/tb_automorph_unit.sv
// Self-checking bench for automorph_unit against a plain-arithmetic automorphism model.
module tb_automorph_unit;
  localparam int unsigned BW   = 54;
  localparam int unsigned LS   = 4;
  localparam int unsigned LOGN = 11;
  localparam int unsigned AW   = 9;
  localparam logic [BW-1:0] Q0 = 54'h3FFFFFFFFED001;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [BW-1:0]   q;
  logic [4:0]      log2_len;
  logic [LOGN:0]   auto_idx;
  logic            busy, done, err;

  automorph_if #(.BIT_WIDTH(BW), .LINE_SIZE(LS), .ADDR_WIDTH(AW)) fif ();

  automorph_unit #(.BIT_WIDTH(BW), .LINE_SIZE(LS), .LOG2_N_MAX(LOGN), .NUM_POLY(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .q(q), .log2_len(log2_len), .auto_idx(auto_idx),
    .busy(busy), .done(done), .err(err), .fifo(fif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [BW-1:0] in_mem  [0:2047];
  logic [BW-1:0] out_mem [0:2047];
  logic [BW-1:0] exp_mem [0:2047];

  // Input FIFO model: line data returns one cycle after the address.
  always @(posedge clk)
    for (int i = 0; i < LS; i++) fif.in_data[i*BW +: BW] <= in_mem[int'(fif.in_addr)*LS + i];

  int errors = 0, checks = 0;
  int t_start, t_first, t_last, t_rdfin, t_wrfin, wen_cycles, bad_wen, rdfin_cnt;
  bit got_first, timed_out, err_seen = 0;

  // Reference: coefficient j goes to pos=(j*k mod 2N) mod N, negated when j*k mod 2N >= N.
  task automatic build_expected(input longint k, input int lg);
    longint n = longint'(1) << lg;
    for (int j = 0; j < n; j++) begin
      longint d = (longint'(j) * k) % (2 * n);
      logic [BW-1:0] c = in_mem[j];
      exp_mem[int'(d % n)] = (d >= n) ? ((c == '0) ? '0 : q - c) : c;
    end
  endtask

  function automatic int count_mis(input int lg, output int first);
    int m = 0;
    first = -1;
    for (int j = 0; j < (1 << lg); j++)
      if (out_mem[j] !== exp_mem[j]) begin
        if (first < 0) first = j;
        m++;
      end
    return m;
  endfunction

  task automatic clear_out();
    for (int j = 0; j < 2048; j++) out_mem[j] = '1;
  endtask

  task automatic pulse_start(input logic [LOGN:0] k, input int lg);
    @(negedge clk);
    auto_idx = k; log2_len = 5'(lg); start = 1'b1; t_start = cyc;
    @(negedge clk);
    start = 1'b0; auto_idx = 12'($urandom);
  endtask

  // Record output-side activity of one polynomial until out_wr_finish or budget expiry.
  task automatic capture_poly(input int budget);
    got_first = 0; wen_cycles = 0; bad_wen = 0; timed_out = 1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (err) err_seen = 1;
      if (|fif.out_wen) begin
        if (!got_first) begin got_first = 1; t_first = cyc; end
        t_last = cyc;
        wen_cycles++;
        if (fif.out_wen !== 4'hF) bad_wen++;
        for (int l = 0; l < LS; l++)
          if (fif.out_wen[l]) out_mem[int'(fif.out_addr[l*AW +: AW])*LS + l] = fif.out_data[l*BW +: BW];
      end
      if (fif.in_rd_finish) begin rdfin_cnt++; t_rdfin = cyc; end
      if (fif.out_wr_finish) begin t_wrfin = cyc; timed_out = 0; break; end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; q = Q0; log2_len = 5'd11; auto_idx = '0;
    fif.in_empty = 1'b0; fif.out_full = 1'b0;
    for (int j = 0; j < 2048; j++) in_mem[j] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, fif.in_rd_finish, fif.out_wr_finish} !== 5'b0 || fif.out_wen !== '0)
      begin errors++; $display("FAIL reset_ctrl: got busy=%b done=%b err=%b wen=%h expected all 0", busy, done, err, fif.out_wen); end
    checks++;
    if (fif.in_addr !== '0 || fif.out_addr !== '0 || fif.out_data !== '0)
      begin errors++; $display("FAIL reset_bus: got in_addr=%0d out_addr=%h expected 0", fif.in_addr, fif.out_addr); end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_identity();
    int m, f, t_w1;
    rdfin_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < 2048; j++) in_mem[j] = (p == 0) ? BW'(j) : BW'(3 * j + 1);
      build_expected(1, 11); clear_out();
      if (p == 0) pulse_start(12'd1, 11);
      capture_poly(600);
      checks++;
      if (timed_out) begin errors++; $display("FAIL ident_timeout p%0d: got no out_wr_finish expected one", p); end
      m = count_mis(11, f);
      checks++;
      if (m !== 0) begin errors++; $display("FAIL ident_data p%0d: got %0d wrong (first idx %0d = %h) expected 0", p, m, f, out_mem[f]); end
      checks++;
      if (wen_cycles !== 512 || bad_wen !== 0) begin errors++; $display("FAIL ident_wen p%0d: got %0d cycles, %0d partial expected 512, 0", p, wen_cycles, bad_wen); end
      checks++;
      if (t_rdfin !== t_last || t_wrfin !== t_last + 1) begin errors++; $display("FAIL ident_finish p%0d: got rd=%0d wr=%0d expected %0d %0d", p, t_rdfin, t_wrfin, t_last, t_last + 1); end
      if (p == 0) begin
        checks++;
        if (t_first !== t_start + 4) begin errors++; $display("FAIL ident_latency: got first wen at %0d expected %0d", t_first, t_start + 4); end
        t_w1 = t_wrfin;
      end else begin
        checks++;
        if (t_wrfin - t_w1 !== 512 + 4) begin errors++; $display("FAIL ident_period: got %0d expected %0d", t_wrfin - t_w1, 516); end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rdfin_cnt !== 2) begin errors++; $display("FAIL ident_done: got done=%b busy=%b rdfin=%0d expected 1 0 2", done, busy, rdfin_cnt); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL ident_done_pulse: got done=%b expected 0", done); end
  endtask

  task automatic test_inverse();
    int m, f;
    for (int j = 0; j < 2048; j++) in_mem[j] = BW'(j + 1);
    build_expected(4095, 11);
    pulse_start(12'd4095, 11);
    for (int p = 0; p < 2; p++) begin
      clear_out();
      capture_poly(600);
      m = count_mis(11, f);
      checks++;
      if (timed_out || m !== 0) begin errors++; $display("FAIL inverse_data p%0d: got %0d wrong (first %0d) timeout=%b expected 0", p, m, f, timed_out); end
    end
    checks++;
    if (out_mem[0] !== BW'(1) || out_mem[2047] !== Q0 - 2 || out_mem[2046] !== Q0 - 3)
      begin errors++; $display("FAIL inverse_points: got %h %h %h expected 1 q-2 q-3", out_mem[0], out_mem[2047], out_mem[2046]); end
    @(negedge clk);
  endtask

  task automatic test_sparse();
    int m, f;
    for (int j = 0; j < 2048; j++) in_mem[j] = '0;
    in_mem[1] = BW'(7); in_mem[410] = BW'(9);
    build_expected(5, 11);
    pulse_start(12'd5, 11);
    clear_out();
    capture_poly(600);
    checks++;
    if (out_mem[5] !== BW'(7) || out_mem[2] !== Q0 - 9) begin errors++; $display("FAIL sparse_points: got out5=%h out2=%h expected 7 q-9", out_mem[5], out_mem[2]); end
    m = count_mis(11, f);
    checks++;
    if (timed_out || m !== 0) begin errors++; $display("FAIL sparse_zero: got %0d wrong (first %0d) expected 0", m, f); end
    capture_poly(600);
    @(negedge clk);
  endtask

  task automatic test_wait_stall();
    logic [AW-1:0] a0;
    int bad = 0, t_rel, m, f;
    fif.in_empty = 1'b1;
    for (int j = 0; j < 2048; j++) in_mem[j] = BW'($urandom) % Q0;
    build_expected(4093, 11);
    pulse_start(12'd4093, 11);
    a0 = fif.in_addr;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fif.in_addr !== a0 || fif.out_wen !== '0 || busy !== 1'b1) bad++;
      if (c == 9) begin fif.in_empty = 1'b0; fif.out_full = 1'b1; end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_wait: got %0d bad cycles expected 0", bad); end
    fif.out_full = 1'b0; t_rel = cyc;
    clear_out();
    capture_poly(600);
    checks++;
    if (t_first !== t_rel + 3) begin errors++; $display("FAIL stall_release: got first wen %0d expected %0d", t_first, t_rel + 3); end
    m = count_mis(11, f);
    checks++;
    if (timed_out || m !== 0) begin errors++; $display("FAIL stall_data: got %0d wrong expected 0", m); end
    capture_poly(600);
    @(negedge clk);
  endtask

  task automatic test_random();
    int m, f, lg;
    logic [LOGN:0] k;
    for (int it = 0; it < 4; it++) begin
      lg = $urandom_range(3, 11);
      k = 12'($urandom) | 12'd1;
      q = (BW'({$urandom, $urandom}) % (Q0 - 1000)) + 1000;
      pulse_start(k, lg);
      for (int p = 0; p < 2; p++) begin
        for (int j = 0; j < (1 << lg); j++) in_mem[j] = ($urandom_range(0, 7) == 0) ? '0 : BW'({$urandom, $urandom}) % q;
        build_expected(longint'(k), lg); clear_out();
        capture_poly((1 << lg) / LS + 40);
        m = count_mis(lg, f);
        checks++;
        if (timed_out || m !== 0 || wen_cycles !== (1 << lg) / LS)
          begin errors++; $display("FAIL rand_data it%0d p%0d: got %0d wrong, %0d wen cycles expected 0, %0d (k=%0d lg=%0d)", it, p, m, wen_cycles, (1 << lg) / LS, k, lg); end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL rand_done it%0d: got %b expected 1", it, done); end
    end
    q = Q0;
    checks++;
    if (err_seen !== 1'b0) begin errors++; $display("FAIL err_idle: got err asserted expected never on odd k"); end
  endtask

  task automatic test_reset_mid();
    int bad = 0, m, f;
    for (int j = 0; j < 2048; j++) in_mem[j] = BW'(j);
    pulse_start(12'd3, 11);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, fif.in_rd_finish, fif.out_wr_finish} !== 5'b0 || fif.out_wen !== '0 ||
        fif.in_addr !== '0 || fif.out_addr !== '0 || fif.out_data !== '0)
      begin errors++; $display("FAIL midreset_clear: got busy=%b wen=%h in_addr=%0d expected all 0", busy, fif.out_wen, fif.in_addr); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (fif.in_rd_finish || fif.out_wr_finish || done || |fif.out_wen) bad++;
    end
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (fif.in_rd_finish || fif.out_wr_finish || done || |fif.out_wen || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad); end
    for (int j = 0; j < 64; j++) in_mem[j] = BW'($urandom) % Q0;
    build_expected(41, 6);
    pulse_start(12'd41, 6);
    for (int p = 0; p < 2; p++) begin
      clear_out();
      capture_poly(60);
      m = count_mis(6, f);
      checks++;
      if (timed_out || m !== 0) begin errors++; $display("FAIL midreset_rerun p%0d: got %0d wrong expected 0", p, m); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL midreset_done: got %b expected 1", done); end
  endtask

  task automatic test_idx_check();
`ifdef AUTOMORPH_IDX_CHECK_EN
    int bad = 0;
    pulse_start(12'd4, 3);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idx_reject: got err=%b busy=%b expected 1 0", err, busy); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (err || busy || |fif.out_wen || fif.in_rd_finish) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL idx_quiet: got %0d active cycles expected 0", bad); end
`else
    err_seen = 0;
    pulse_start(12'd4, 3);
    capture_poly(30);
    capture_poly(30);
    @(negedge clk);
    if (err) err_seen = 1;
    checks++;
    if (err_seen !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL idx_even_run: got err_seen=%b done=%b expected 0 1", err_seen, done); end
`endif
  endtask

  initial begin
    test_reset();
    test_identity();
    test_inverse();
    test_sparse();
    test_wait_stall();
    test_random();
    test_reset_mid();
    test_idx_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
